// File: rtl/queue_drain_display_pkg.sv
// Shared FSM encoding and active-low hex glyph table (gfedcba) for queue_drain_display.
package queue_drain_display_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPop  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [6:0] Seg7Blank = 7'h7f;

  // Index 15 is leftmost: F, E, d, C, b, A, 9 .. 0.
  localparam logic [15:0][6:0] Seg7Hex = {
    7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] digit);
    return Seg7Hex[digit];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment (gfedcba) decoder.
module hex_to_seg7
  import queue_drain_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_glyph(hex_i);
  end

endmodule

// File: rtl/queue_drain_display.sv
// Drains a FWFT queue one entry at a time, holding each value for HOLD_TICKS cycles.
// Optional 7-segment output enabled by defining QUEUE_DRAIN_SEG7_EN.
module queue_drain_display
  import queue_drain_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned HOLD_TICKS  = 50000000,
  parameter int unsigned HOLD_WIDTH  = 26,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   q_empty,
  input  logic [DATA_WIDTH-1:0]  q_read_data,
  output logic                   q_read_cmd,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pop_count
`ifdef QUEUE_DRAIN_SEG7_EN
  ,
  output logic [6:0]             seg
`endif
);

  localparam logic [HOLD_WIDTH-1:0] HoldLast = HOLD_WIDTH'(HOLD_TICKS - 1);

  state_e                 state_q, state_d;
  logic                   q_read_cmd_q, q_read_cmd_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic [HOLD_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    pop_count_d  = pop_count_q;
    hold_cnt_d   = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable && !q_empty) state_d = StPop;
      end
      StPop: begin
        // Another reader may have emptied the queue; then nothing is taken.
        if (!q_empty) begin
          data_out_d   = q_read_data;
          data_valid_d = 1'b1;
          pop_count_d  = pop_count_q + COUNT_WIDTH'(1);
          hold_cnt_d   = '0;
          state_d      = StHold;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they stay Moore.
    q_read_cmd_d = (state_d == StPop);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      q_read_cmd_q <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      pop_count_q  <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      q_read_cmd_q <= q_read_cmd_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      pop_count_q  <= pop_count_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign q_read_cmd = q_read_cmd_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign pop_count  = pop_count_q;

`ifdef QUEUE_DRAIN_SEG7_EN
  logic [6:0] seg_dec;
  logic [6:0] seg_q, seg_d;

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (data_out_q[3:0]),
    .seg_o (seg_dec)
  );

  always_comb begin
    seg_d = data_valid_q ? seg_dec : Seg7Blank;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_q <= Seg7Blank;
    else       seg_q <= seg_d;
  end

  assign seg = seg_q;
`endif

endmodule

// File: tb/tb_queue_drain_display.sv
// Self-checking bench for queue_drain_display with a FWFT queue model and popped-value scoreboard.
module tb_queue_drain_display;

  localparam int unsigned DW = 4;
  localparam int unsigned HT = 4;
  localparam int unsigned HW = 3;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          q_empty;
  logic [DW-1:0] q_read_data;
  logic          q_read_cmd;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic [CW-1:0] pop_count;
`ifdef QUEUE_DRAIN_SEG7_EN
  logic [6:0]    seg;
`endif

  queue_drain_display #(
    .DATA_WIDTH  (DW),
    .HOLD_TICKS  (HT),
    .HOLD_WIDTH  (HW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .q_empty     (q_empty),
    .q_read_data (q_read_data),
    .q_read_cmd  (q_read_cmd),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .pop_count   (pop_count)
`ifdef QUEUE_DRAIN_SEG7_EN
    ,
    .seg         (seg)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] model_count;
  int pulse_cyc[$];

  task automatic sync_q();
    q_empty     = (fifo.size() == 0);
    q_read_data = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // Queue model: a pop happens on the edge that ends a read-command cycle.
  always @(posedge clk) begin : queue_model
    logic cmd_s;
    logic empty_s;
    logic [DW-1:0] v;
    cyc     = cyc + 1;
    cmd_s   = q_read_cmd;
    empty_s = q_empty;
    #1;
    if (!reset && cmd_s) begin
      pulse_cyc.push_back(cyc);
      if (!empty_s) begin
        v = fifo.pop_front();
        exp_q.push_back(v);
        model_count = model_count + 8'd1;
        sync_q();
      end
    end
  end

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    fifo.delete();
    exp_q.delete();
    pulse_cyc.delete();
    model_count = '0;
    sync_q();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    bit found;
    reset = 1'b1; enable = 1'b0; model_count = '0; sync_q();
    #2;
    checks++;
    if ({q_read_cmd, data_out, data_valid, busy, pop_count} !== '0) begin
      failures++;
      $display("FAIL reset_state: cmd=%b data=%h valid=%b busy=%b count=%0d, required all zero",
               q_read_cmd, data_out, data_valid, busy, pop_count);
    end
`ifdef QUEUE_DRAIN_SEG7_EN
    checks++;
    if (seg !== 7'b1111111) begin
      failures++; $display("FAIL reset_seg: got %b required 1111111", seg);
    end
`endif
    do_reset();
    fifo.push_back(4'h9); sync_q(); enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = q_read_cmd;
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (!found || data_out !== e || busy !== 1'b1) begin
        failures++;
        $display("FAIL pre_reset_hold: data=%h busy=%b found=%b, required data=%h busy=1",
                 data_out, busy, found, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({q_read_cmd, data_out, data_valid, busy, pop_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid_hold: cmd=%b data=%h valid=%b busy=%b count=%0d, required all zero",
               q_read_cmd, data_out, data_valid, busy, pop_count);
    end
    do_reset();
    fifo.push_back(4'h6); sync_q(); enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = q_read_cmd;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (!found || q_read_cmd !== 1'b0 || pop_count !== '0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_pop: found=%b cmd=%b count=%0d valid=%b, required cmd=0 count=0 valid=0",
               found, q_read_cmd, pop_count, data_valid);
    end
    @(posedge clk); #2;
    checks++;
    if (pop_count !== '0 || data_out !== '0) begin
      failures++;
      $display("FAIL reset_no_partial_pop: count=%0d data=%h, required 0 and 0", pop_count, data_out);
    end
    do_reset();
  endtask

  task automatic test_sequence();
    logic [DW-1:0] e;
    logic [DW-1:0] seen[$];
    logic [DW-1:0] want[3];
    want[0] = 4'h3; want[1] = 4'h7; want[2] = 4'hB;
    do_reset();
    fifo = '{4'h3, 4'h7, 4'hB}; sync_q();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        seen.push_back(data_out);
        checks++;
        if (data_out !== e || pop_count !== model_count) begin
          failures++;
          $display("FAIL seq_scoreboard: data=%h count=%0d, required data=%h count=%0d",
                   data_out, pop_count, e, model_count);
        end
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== want[0] || seen[1] !== want[1] || seen[2] !== want[2]) begin
      failures++;
      $display("FAIL seq_order: got %0d values, required 3 values 3,7,B", seen.size());
    end
    checks++;
    if (pulse_cyc.size() != 3) begin
      failures++; $display("FAIL seq_pulses: got %0d required 3", pulse_cyc.size());
    end else begin
      checks++;
      if (pulse_cyc[1] - pulse_cyc[0] != 6 || pulse_cyc[2] - pulse_cyc[1] != 6) begin
        failures++;
        $display("FAIL seq_spacing: got %0d,%0d required 6,6",
                 pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1]);
      end
    end
    checks++;
    if (pop_count !== 8'd3 || data_out !== 4'hB || busy !== 1'b0 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL seq_final: count=%0d data=%h busy=%b valid=%b, required 3 B 0 1",
               pop_count, data_out, busy, data_valid);
    end
  endtask

  task automatic test_empty();
    int bad;
    do_reset();
    enable = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || data_valid || q_read_cmd) bad++;
    end
    checks++;
    if (bad != 0 || pulse_cyc.size() != 0) begin
      failures++;
      $display("FAIL empty_idle: active_cycles=%0d pulses=%0d, required 0 and 0", bad, pulse_cyc.size());
    end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] e;
    bit found;
    int busy_n;
    do_reset();
    fifo = '{4'h1, 4'h2}; sync_q();
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = q_read_cmd;
    end
    @(negedge clk);
    enable = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_n++;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e) begin
          failures++; $display("FAIL drop_scoreboard: got %h required %h", data_out, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!found || busy_n != 4 || pulse_cyc.size() != 1 || data_out !== 4'h1) begin
      failures++;
      $display("FAIL drop_hold: found=%b busy_cycles=%0d pulses=%0d data=%h, required 1 4 1 1",
               found, busy_n, pulse_cyc.size(), data_out);
    end
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(negedge clk);
      found = q_read_cmd;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reenable_pop: got no pulse within 2 cycles, required pulse");
    end
    repeat (8) @(negedge clk);
    checks++;
    if (data_out !== 4'h2 || pop_count !== 8'd2 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL reenable_data: data=%h count=%0d pending=%0d, required 2 2 1",
               data_out, pop_count, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e;
    bit done;
    int seen;
    do_reset();
    repeat (256) fifo.push_back(4'h5);
    sync_q();
    enable = 1'b1;
    done = 0; seen = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        seen++;
        checks++;
        if (data_out !== e || pop_count !== model_count) begin
          failures++;
          $display("FAIL wrap_scoreboard: data=%h count=%0d, required data=%h count=%0d",
                   data_out, pop_count, e, model_count);
        end
      end
      done = (fifo.size() == 0) && !busy;
    end
    checks++;
    if (!done || seen != 256 || pop_count !== 8'd0 || data_out !== 4'h5 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_final: done=%b pops=%0d count=%0d data=%h valid=%b, required 1 256 0 5 1",
               done, seen, pop_count, data_out, data_valid);
    end
  endtask

`ifdef QUEUE_DRAIN_SEG7_EN
  task automatic test_seg();
    bit found;
    do_reset();
    checks++;
    if (seg !== 7'b1111111) begin
      failures++; $display("FAIL seg_blank: got %b required 1111111", seg);
    end
    fifo.push_back(4'hA); sync_q(); enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = q_read_cmd;
    end
    @(negedge clk);
    checks++;
    if (!found || data_out !== 4'hA || seg !== 7'b1111111) begin
      failures++;
      $display("FAIL seg_lag: found=%b data=%h seg=%b, required data=A seg=1111111", found, data_out, seg);
    end
    @(negedge clk);
    checks++;
    if (seg !== 7'b0001000) begin
      failures++; $display("FAIL seg_glyph_a: got %b required 0001000", seg);
    end
    exp_q.delete();
  endtask
`endif

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequence();
    test_empty();
    test_enable_drop();
    test_wrap();
`ifdef QUEUE_DRAIN_SEG7_EN
    test_seg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
